// File: rtl/ppu_pkg.sv
// Shared PPU timing types: STAT mode encoding and default scanline geometry.
package ppu_pkg;

  typedef logic [1:0] ppu_mode_t;

  localparam ppu_mode_t MODE_HBLANK = 2'd0;
  localparam ppu_mode_t MODE_VBLANK = 2'd1;
  localparam ppu_mode_t MODE_OAM    = 2'd2;
  localparam ppu_mode_t MODE_DRAW   = 2'd3;

  localparam int unsigned DEF_DOTS_PER_LINE   = 456;
  localparam int unsigned DEF_LINES_PER_FRAME = 154;
  localparam int unsigned DEF_VISIBLE_LINES   = 144;
  localparam int unsigned DEF_OAM_DOTS        = 80;
  localparam int unsigned DEF_MODE3_MIN       = 172;
  localparam int unsigned DEF_MODE3_MAX       = 289;

endpackage

// File: rtl/ppu_dot_line_counter.sv
// Dot/line position counters with wrap; advance or clear on qualified dots.
// Next position is exposed combinationally so the top can register outputs in lockstep.
module ppu_dot_line_counter
  import ppu_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       adv_i,
  input  logic       clr_i,
  output logic [8:0] dot_o,
  output logic [8:0] nxt_dot_o,
  output logic [7:0] nxt_line_o,
  output logic       wrap_o
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LINE_LAST = 8'(LINES_PER_FRAME - 1);

  logic [8:0] dot_q, dot_d;
  logic [7:0] line_q, line_d;

  always_comb begin
    wrap_o     = (dot_q == DOT_LAST);
    nxt_dot_o  = wrap_o ? 9'd0 : dot_q + 9'd1;
    nxt_line_o = line_q;
    if (wrap_o) begin
      nxt_line_o = (line_q == LINE_LAST) ? 8'd0 : line_q + 8'd1;
    end
    dot_d  = dot_q;
    line_d = line_q;
    if (clr_i) begin
      dot_d  = 9'd0;
      line_d = 8'd0;
    end else if (adv_i) begin
      dot_d  = nxt_dot_o;
      line_d = nxt_line_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      dot_q  <= 9'd0;
      line_q <= 8'd0;
    end else begin
      dot_q  <= dot_d;
      line_q <= line_d;
    end
  end

  assign dot_o = dot_q;

endmodule

// File: rtl/ppu_timing_controller.sv
// PPU mode sequencer: STAT mode, LY, LY==LYC and one-dot strobes, all registered.
// Outputs describe the position the counters hold; everything advances only on dot_en.
module ppu_timing_controller
  import ppu_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int unsigned VISIBLE_LINES   = DEF_VISIBLE_LINES,
  parameter int unsigned OAM_DOTS        = DEF_OAM_DOTS,
  parameter int unsigned MODE3_MIN       = DEF_MODE3_MIN,
  parameter int unsigned MODE3_MAX       = DEF_MODE3_MAX,
  parameter bit          LY153_QUIRK     = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       dot_en_i,
  input  logic       ppu_enable_i,
  input  logic [7:0] lyc_i,
  input  logic       draw_done_i,
  output logic [1:0] mode_o,
  output logic [7:0] ly_o,
  output logic [8:0] dot_o,
  output logic       ly_compare_o,
  output logic       oam_scan_start_o,
  output logic       draw_start_o,
  output logic       hblank_start_o,
  output logic       frame_start_o,
  output logic       mode3_overrun_o
);

  localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] M3_MIN    = 9'(MODE3_MIN);
  localparam logic [8:0] M3_MAX    = 9'(MODE3_MAX);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
  localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);
  localparam logic [8:0] QUIRK_DOT = 9'd4;

  logic       adv, clr, wrap;
  logic [8:0] nxt_dot;
  logic [7:0] nxt_line;

  ppu_mode_t  mode_q, mode_d;
  logic [7:0] ly_q, ly_d;
  logic [8:0] m3len_q, m3len_d;
  logic       first_line_q, first_line_d;
  logic       ly_cmp_q, ly_cmp_d;
  logic       oam_q, oam_d, draw_q, draw_d, hbl_q, hbl_d;
  logic       frame_q, frame_d, ovr_q, ovr_d;

  assign adv = dot_en_i & ppu_enable_i;
  assign clr = dot_en_i & ~ppu_enable_i;

  ppu_dot_line_counter #(
    .DOTS_PER_LINE  (DOTS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .adv_i     (adv),
    .clr_i     (clr),
    .dot_o     (dot_o),
    .nxt_dot_o (nxt_dot),
    .nxt_line_o(nxt_line),
    .wrap_o    (wrap)
  );

  // Mode and strobes are decided for the position the counters are about to take.
  always_comb begin
    mode_d       = mode_q;
    ly_d         = ly_q;
    m3len_d      = m3len_q;
    first_line_d = first_line_q;
    ly_cmp_d     = ly_cmp_q;
    oam_d        = 1'b0;
    draw_d       = 1'b0;
    hbl_d        = 1'b0;
    frame_d      = 1'b0;
    ovr_d        = 1'b0;
    if (dot_en_i) begin
      ly_cmp_d = (ly_q == lyc_i);
      if (!ppu_enable_i) begin
        mode_d       = MODE_HBLANK;
        ly_d         = 8'd0;
        m3len_d      = 9'd0;
        first_line_d = 1'b1;
      end else begin
        if (wrap) first_line_d = 1'b0;
        ly_d = (LY153_QUIRK && nxt_line == LAST_LINE && nxt_dot >= QUIRK_DOT) ? 8'd0 : nxt_line;
        if (nxt_line >= VIS_LINES) begin
          mode_d  = MODE_VBLANK;
          frame_d = (nxt_line == VIS_LINES) && (nxt_dot == 9'd0);
        end else if (nxt_dot < OAM_END) begin
          mode_d = first_line_d ? MODE_HBLANK : MODE_OAM;
          oam_d  = (nxt_dot == 9'd0) && !first_line_d;
        end else if (nxt_dot == OAM_END) begin
          mode_d  = MODE_DRAW;
          draw_d  = 1'b1;
          m3len_d = 9'd1;
        end else if (mode_q == MODE_DRAW) begin
          if (m3len_q >= M3_MIN && draw_done_i) begin
            mode_d = MODE_HBLANK;
            hbl_d  = 1'b1;
          end else if (m3len_q >= M3_MAX) begin
            mode_d = MODE_HBLANK;
            hbl_d  = 1'b1;
            ovr_d  = 1'b1;
          end else begin
            m3len_d = m3len_q + 9'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mode_q       <= MODE_HBLANK;
      ly_q         <= 8'd0;
      m3len_q      <= 9'd0;
      first_line_q <= 1'b1;
      ly_cmp_q     <= 1'b0;
      oam_q        <= 1'b0;
      draw_q       <= 1'b0;
      hbl_q        <= 1'b0;
      frame_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      ly_q         <= ly_d;
      m3len_q      <= m3len_d;
      first_line_q <= first_line_d;
      ly_cmp_q     <= ly_cmp_d;
      oam_q        <= oam_d;
      draw_q       <= draw_d;
      hbl_q        <= hbl_d;
      frame_q      <= frame_d;
      ovr_q        <= ovr_d;
    end
  end

  assign mode_o           = mode_q;
  assign ly_o             = ly_q;
  assign ly_compare_o     = ly_cmp_q;
  assign oam_scan_start_o = oam_q;
  assign draw_start_o     = draw_q;
  assign hblank_start_o   = hbl_q;
  assign frame_start_o    = frame_q;
  assign mode3_overrun_o  = ovr_q;

endmodule

// File: tb/tb_ppu_timing_controller.sv
// Bench for ppu_timing_controller: absolute-position reference model checked every cycle,
// plus directed checks on reset, mode-3 bounds, VBlank, LY153 quirk, LYC compare and enable.
module tb_ppu_timing_controller;

  localparam int DPL   = 456;
  localparam int LPF   = 154;
  localparam int VIS   = 144;
  localparam int OAMD  = 80;
  localparam int M3MIN = 172;
  localparam int M3MAX = 289;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dot_en = 1'b0;
  logic       ppu_enable = 1'b0;
  logic       draw_done = 1'b0;
  logic [7:0] lyc = 8'd5;
  logic [1:0] mode_o;
  logic [7:0] ly_o;
  logic [8:0] dot_o;
  logic       ly_compare_o, oam_scan_start_o, draw_start_o, hblank_start_o;
  logic       frame_start_o, mode3_overrun_o;

  always #5 clk = ~clk;

  ppu_timing_controller dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .dot_en_i        (dot_en),
    .ppu_enable_i    (ppu_enable),
    .lyc_i           (lyc),
    .draw_done_i     (draw_done),
    .mode_o          (mode_o),
    .ly_o            (ly_o),
    .dot_o           (dot_o),
    .ly_compare_o    (ly_compare_o),
    .oam_scan_start_o(oam_scan_start_o),
    .draw_start_o    (draw_start_o),
    .hblank_start_o  (hblank_start_o),
    .frame_start_o   (frame_start_o),
    .mode3_overrun_o (mode3_overrun_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: absolute dot position in the frame, first-line flag, dot where
  // HBlank began on the current line (-1 while undecided), compare flag, pulses.
  int       m_pos   = 0;
  bit       m_first = 1'b1;
  int       m_end   = -1;
  bit       m_cmp   = 1'b0;
  bit [4:0] m_pul   = 5'b0;  // {oam, draw, hblank, frame, overrun}

  function automatic int exp_ly(int pos);
    int line = pos / DPL;
    int d    = pos % DPL;
    return (line == LPF - 1 && d >= 4) ? 0 : line;
  endfunction

  function automatic int exp_mode(int pos, bit first, int hb);
    int line = pos / DPL;
    int d    = pos % DPL;
    if (line >= VIS) return 1;
    if (d < OAMD) return first ? 0 : 2;
    if (hb < 0 || d < hb) return 3;
    return 0;
  endfunction

  task automatic model_edge(bit en, bit dd, logic [7:0] lyc_v);
    int line = m_pos / DPL;
    int d    = m_pos % DPL;
    int len;
    m_pul = 5'b0;
    m_cmp = (exp_ly(m_pos) == int'(lyc_v));
    if (!en) begin
      m_pos   = 0;
      m_first = 1'b1;
      m_end   = -1;
      return;
    end
    if (line < VIS && d >= OAMD && m_end < 0) begin
      len = d - OAMD + 1;
      if (len >= M3MIN && dd) begin
        m_end    = d + 1;
        m_pul[2] = 1'b1;
      end else if (len >= M3MAX) begin
        m_end    = d + 1;
        m_pul[2] = 1'b1;
        m_pul[0] = 1'b1;
      end
    end
    m_pos = (m_pos + 1) % (DPL * LPF);
    line  = m_pos / DPL;
    d     = m_pos % DPL;
    if (d == 0) begin
      m_first = 1'b0;
      m_end   = -1;
    end
    m_pul[4] = (d == 0) && (line < VIS) && !m_first;
    m_pul[3] = (d == OAMD) && (line < VIS);
    m_pul[1] = (d == 0) && (line == VIS);
  endtask

  task automatic check_outputs();
    logic [24:0] got;
    logic [24:0] exp;
    got = {mode_o, ly_o, dot_o, ly_compare_o, oam_scan_start_o, draw_start_o,
           hblank_start_o, frame_start_o, mode3_overrun_o};
    exp = {2'(exp_mode(m_pos, m_first, m_end)), 8'(exp_ly(m_pos)), 9'(m_pos % DPL),
           m_cmp, m_pul};
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL outputs line %0d dot %0d: got mode=%0d ly=%0d dot=%0d cmp=%b pulses=%b, expected mode=%0d ly=%0d dot=%0d cmp=%b pulses=%b",
             m_pos / DPL, m_pos % DPL, got[24:23], got[22:15], got[14:6], got[5], got[4:0],
             exp[24:23], exp[22:15], exp[14:6], exp[5], exp[4:0]);
    end
  endtask

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(bit en, bit pe, bit dd, bit rn);
    dot_en     = en;
    ppu_enable = pe;
    draw_done  = dd;
    reset_n    = rn;
    @(posedge clk);
    if (!rn) begin
      m_pos   = 0;
      m_first = 1'b1;
      m_end   = -1;
      m_cmp   = 1'b0;
      m_pul   = 5'b0;
    end else if (en) begin
      model_edge(pe, dd, lyc);
    end else begin
      m_pul = 5'b0;
    end
    #1;
    check_outputs();
  endtask

  int hbl_dot [LPF];
  int ovr_line2, oam_line0, frame_pos, vbl_dots, ly153_d3, ly153_d4;
  int rise_q[$];
  int fall_q[$];
  bit prev_cmp;

  initial begin
    int kind, pdot, line, guard, cnt;
    bit dd;
    foreach (hbl_dot[i]) hbl_dot[i] = -1;
    ovr_line2 = 0; oam_line0 = 0; frame_pos = -1; vbl_dots = 0;
    ly153_d3 = -1; ly153_d4 = -1;

    // Reset with irregular dot_en.
    for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    chk("reset_mode", int'(mode_o), 0);
    chk("reset_ly", int'(ly_o), 0);
    chk("reset_dot", int'(dot_o), 0);
    chk("reset_cmp", int'(ly_compare_o), 0);
    chk("reset_pulses", int'({oam_scan_start_o, draw_start_o, hblank_start_o,
                              frame_start_o, mode3_overrun_o}), 0);

    // One full frame from enable; per-line draw_done styles.
    prev_cmp = ly_compare_o;
    for (int l = 0; l < LPF; l++) begin
      if (l == 10) lyc = 8'd0;
      kind = (l == 0) ? 4 : (l == 1) ? 0 : (l == 2) ? 1 : int'($urandom_range(0, 3));
      pdot = int'($urandom_range(80, 400));
      for (int d = 0; d < DPL; d++) begin
        case (kind)
          0:       dd = 1'b1;
          1:       dd = 1'b0;
          2:       dd = (d == pdot);
          3:       dd = ($urandom_range(0, 5) == 0);
          default: dd = (d == 251);  // sampled on the edge that produces dot 252
        endcase
        tick(1'b1, 1'b1, dd, 1'b1);
        line = m_pos / DPL;
        if (hblank_start_o && hbl_dot[line] < 0) hbl_dot[line] = int'(dot_o);
        if (mode3_overrun_o && line == 2) ovr_line2++;
        if (oam_scan_start_o && line == 0 && l == 0) oam_line0++;
        if (frame_start_o) frame_pos = m_pos;
        if (mode_o == 2'd1) vbl_dots++;
        if (line == LPF - 1 && m_pos % DPL == 3) ly153_d3 = int'(ly_o);
        if (line == LPF - 1 && m_pos % DPL == 4) ly153_d4 = int'(ly_o);
        if (ly_compare_o && !prev_cmp) rise_q.push_back(m_pos);
        if (!ly_compare_o && prev_cmp) fall_q.push_back(m_pos);
        prev_cmp = ly_compare_o;
      end
    end
    chk("first_line_hblank_dot", hbl_dot[0], 252);
    chk("first_line_no_oam", oam_line0, 0);
    chk("held_draw_done_hblank_dot", hbl_dot[1], 252);
    chk("overrun_hblank_dot", hbl_dot[2], 369);
    chk("overrun_pulses", ovr_line2, 1);
    chk("frame_start_pos", frame_pos, VIS * DPL);
    chk("vblank_dots", vbl_dots, 4560);
    chk("ly153_dot3", ly153_d3, 153);
    chk("ly153_dot4", ly153_d4, 0);
    chk("cmp_rise_count", rise_q.size(), 2);
    chk("cmp_rise_ly5", (rise_q.size() > 0) ? rise_q[0] : -1, 5 * DPL + 1);
    chk("cmp_fall_ly6", (fall_q.size() > 0) ? fall_q[0] : -1, 6 * DPL + 1);
    chk("cmp_rise_quirk", (rise_q.size() > 1) ? rise_q[1] : -1, 153 * DPL + 5);
    chk("wrap_oam_start", int'(oam_scan_start_o), 1);
    chk("wrap_mode", int'(mode_o), 2);

    // Drop enable mid-frame, let LY==LYC track 0, then re-enable.
    guard = 0;
    while (!(ly_o == 8'd5 && dot_o == 9'd200) && guard < 4000) begin
      tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      guard++;
    end
    chk("reach_ly5_dot200", int'(dot_o) + 1000 * int'(ly_o), 5200);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("disable_mode", int'(mode_o), 0);
    chk("disable_ly", int'(ly_o), 0);
    chk("disable_dot", int'(dot_o), 0);
    lyc = 8'd0;
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    chk("disabled_cmp_tracks", int'(ly_compare_o), 1);
    lyc = 8'd7;
    cnt = 0;
    for (int i = 0; i < DPL - 1; i++) begin
      tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      if (oam_scan_start_o || mode_o == 2'd2) cnt++;
    end
    chk("reenable_skips_oam", cnt, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("reenable_line1_oam", int'(oam_scan_start_o), 1);
    chk("reenable_line1_ly", int'(ly_o), 1);

    // Irregular dot_en into mode 3, then reset mid-draw.
    guard = 0;
    while (!(ly_o == 8'd1 && dot_o >= 9'd150) && guard < 3000) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      guard++;
    end
    chk("pre_reset_mode3", int'(mode_o), 3);
    for (int i = 0; i < 5; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    chk("midframe_reset_mode", int'(mode_o), 0);
    chk("midframe_reset_ly", int'(ly_o), 0);
    chk("midframe_reset_dot", int'(dot_o), 0);
    chk("midframe_reset_cmp", int'(ly_compare_o), 0);
    chk("midframe_reset_pulses", int'({oam_scan_start_o, draw_start_o, hblank_start_o,
                                       frame_start_o, mode3_overrun_o}), 0);
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
